kamus_fetch_unit: RTL and testbench

// - Instruction-fetch stage of the kamus-v core, directly upstream of decode and the control unit.
// - Holds the PC and issues requests to L1I.
// - Buffers fetched {pc, instr} pairs for decode.
// - Steers next-PC from the control unit's instr_addr_state (PC4_ST / B_ST / J_ST) plus the branch outcome.
// - On a redirect, flushes the buffer and drops any in-flight response.

---
 rtl/kamus_pkg.sv | 30 +++
 rtl/kamus_fetch_unit_if.sv | 31 +++
 rtl/kamus_fetch_fifo.sv | 61 ++++++
 rtl/kamus_fetch_unit.sv | 126 ++++++++++++
 tb/tb_kamus_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus-v fetch stage.
package kamus_pkg;

  localparam int unsigned     KAMUS_XLEN      = 32;
  localparam logic [31:0]     KAMUS_BOOT_ADDR = 32'h0000_0000;

  // Next-PC selector produced by the control unit
  typedef enum logic [1:0] {
    PC4_ST = 2'b00,
    B_ST   = 2'b01,
    J_ST   = 2'b10
  } instr_addr_state_t;

  // Fetch FSM encoding kept as plain constants so older tools can consume it
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH_REQ   = 2'd0;
  localparam fetch_state_t FETCH_WAIT  = 2'd1;
  localparam fetch_state_t FETCH_FLUSH = 2'd2;

  typedef struct packed {
    logic [KAMUS_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary
  function automatic logic [KAMUS_XLEN-1:0] word_align(input logic [KAMUS_XLEN-1:0] addr);
    return {addr[KAMUS_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/kamus_fetch_unit_if.sv
// L1I request/response bus and decode hand-off bundled for the fetch stage.
interface kamus_fetch_unit_if
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN = KAMUS_XLEN
);

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;

  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;

  // Fetch unit side
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

  // L1I / decode side
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

endinterface

// File: rtl/kamus_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs for decode.
// Clear wins over push and pop in the same cycle.
module kamus_fetch_fifo
  import kamus_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = pop_i && (r_count != '0);
  assign w_do_push = push_i && ((r_count != FULL_CNT) || w_do_pop);

  // Storage; reset so the head reads zero while the stage is held in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !clear_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/kamus_fetch_unit.sv
// Instruction-fetch stage: PC register, L1I request FSM, redirect handling.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FETCH_REQ   | request pc to L1I whenever the buffer has room
// FETCH_WAIT  | one request granted, waiting for its rvalid to push
// FETCH_FLUSH | a redirect orphaned the in-flight request; drop its rvalid
module kamus_fetch_unit
  import kamus_pkg::*;
#(
  parameter int unsigned     XLEN      = KAMUS_XLEN,
  parameter logic [XLEN-1:0] BOOT_ADDR = KAMUS_BOOT_ADDR,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ctrl_valid_i,
  input  instr_addr_state_t instr_addr_state_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   target_addr_i,
  kamus_fetch_unit_if.master fetch_if,
  output logic              fetch_misalign_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_req_pc;

  logic            w_redirect;
  logic            w_outstanding;
  logic            w_req;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_redirect = ctrl_valid_i &&
                      ((instr_addr_state_i == J_ST) ||
                       ((instr_addr_state_i == B_ST) && branch_taken_i));

  // Only WAIT owes a response that will land in the buffer
  assign w_outstanding = (r_state == FETCH_WAIT);
  assign w_req   = (r_state == FETCH_REQ) &&
                   ((w_count + CW'(w_outstanding)) < CW'(BUF_DEPTH));
  assign w_grant = w_req && fetch_if.imem_gnt_i;

  assign w_push = (r_state == FETCH_WAIT) && fetch_if.imem_rvalid_i && !w_redirect;
  assign w_pop  = fetch_if.instr_valid_o && fetch_if.instr_ready_i;
  assign w_push_entry = '{pc: r_req_pc, instr: fetch_if.imem_rdata_i};

  // Next state and next PC; a redirect overrides any sequential advance
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (w_redirect) begin
      w_pc_nxt = word_align(target_addr_i);
      case (r_state)
        FETCH_REQ:   if (w_grant) w_state_nxt = FETCH_FLUSH;
        FETCH_WAIT:  w_state_nxt = fetch_if.imem_rvalid_i ? FETCH_REQ : FETCH_FLUSH;
        FETCH_FLUSH: if (fetch_if.imem_rvalid_i) w_state_nxt = FETCH_REQ;
        default:     w_state_nxt = FETCH_REQ;
      endcase
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (w_grant) begin
            w_pc_nxt    = r_pc + XLEN'(4);
            w_state_nxt = FETCH_WAIT;
          end
        end
        FETCH_WAIT:  if (fetch_if.imem_rvalid_i) w_state_nxt = FETCH_REQ;
        FETCH_FLUSH: if (fetch_if.imem_rvalid_i) w_state_nxt = FETCH_REQ;
        default:     w_state_nxt = FETCH_REQ;
      endcase
    end
  end

  // FSM and PC registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FETCH_REQ;
      r_pc    <= BOOT_ADDR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Remember the address of the granted request so its response is tagged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_pc <= BOOT_ADDR;
    end else if (w_grant && !w_redirect) begin
      r_req_pc <= r_pc;
    end
  end

  kamus_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .clear_i (w_redirect),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // Request/redirect-derived outputs are forced low while reset is asserted
  assign fetch_if.imem_req_o  = rst_ni && w_req;
  assign fetch_if.imem_addr_o = rst_ni ? r_pc : '0;
  assign fetch_misalign_o     = rst_ni && w_redirect && (target_addr_i[1:0] != 2'b00);

  assign fetch_if.instr_valid_o = (w_count != '0);
  assign fetch_if.instr_o       = w_head.instr;
  assign fetch_if.instr_pc_o    = w_head.pc;

endmodule

// File: tb/tb_kamus_fetch_unit.sv
// Directed bench for kamus_fetch_unit with a queue-based reference model.
module tb_kamus_fetch_unit;
  import kamus_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ctrl_valid = 1'b0;
  instr_addr_state_t st = PC4_ST;
  logic              taken = 1'b0;
  logic [XLEN-1:0]   target = '0;
  logic              misalign;
  logic              gnt_en = 1'b0;
  int                resp_lat = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kamus_fetch_unit_if #(.XLEN(XLEN)) ifc ();

  assign ifc.imem_gnt_i = ifc.imem_req_o & gnt_en;

  kamus_fetch_unit #(
    .XLEN      (XLEN),
    .BOOT_ADDR (32'h0000_0000),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ctrl_valid_i       (ctrl_valid),
    .instr_addr_state_i (st),
    .branch_taken_i     (taken),
    .target_addr_i      (target),
    .fetch_if           (ifc.master),
    .fetch_misalign_o   (misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- L1I responder: one outstanding, rvalid resp_lat cycles late
  logic [31:0] resp_addr;
  initial begin
    ifc.imem_rvalid_i = 1'b0;
    ifc.imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.imem_req_o && ifc.imem_gnt_i) begin
        resp_addr = ifc.imem_addr_o;
        @(posedge clk);
        repeat (resp_lat) @(posedge clk);
        #1;
        ifc.imem_rvalid_i = 1'b1;
        ifc.imem_rdata_i  = mem_word(resp_addr);
        @(posedge clk);
        #1;
        ifc.imem_rvalid_i = 1'b0;
        ifc.imem_rdata_i  = '0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare
  logic [31:0] m_buf[$];
  logic [31:0] pop_log[$];
  logic [31:0] gnt_log[$];
  bit          m_pend = 0;
  logic [31:0] m_pend_pc = '0;
  bit          m_stale = 0;
  logic [31:0] m_next_pc = '0;
  int          misalign_cnt = 0;

  always @(negedge clk) begin : model
    bit exp_req, redir, grant, rv, pop;
    if (!rst_n) begin
      chk("rst_req",   {31'b0, ifc.imem_req_o}, 0);
      chk("rst_addr",  ifc.imem_addr_o, 0);
      chk("rst_valid", {31'b0, ifc.instr_valid_o}, 0);
      chk("rst_instr", ifc.instr_o, 0);
      chk("rst_pc",    ifc.instr_pc_o, 0);
      chk("rst_mis",   {31'b0, misalign}, 0);
      m_buf.delete();
      m_pend    = 0;
      m_stale   = 0;
      m_next_pc = 32'h0;
    end else begin
      exp_req = !m_pend && !m_stale && (m_buf.size() < DEPTH);
      chk("req", {31'b0, ifc.imem_req_o}, {31'b0, exp_req});
      if (exp_req) chk("addr", ifc.imem_addr_o, m_next_pc);
      chk("valid", {31'b0, ifc.instr_valid_o}, {31'b0, m_buf.size() != 0});
      if (m_buf.size() != 0) begin
        chk("head_pc",    ifc.instr_pc_o, m_buf[0]);
        chk("head_instr", ifc.instr_o, mem_word(m_buf[0]));
      end
      redir = ctrl_valid && (st == J_ST || (st == B_ST && taken));
      chk("misalign", {31'b0, misalign}, {31'b0, redir && (target[1:0] != 2'b00)});
      if (misalign) misalign_cnt++;

      grant = exp_req && gnt_en;
      rv    = ifc.imem_rvalid_i;
      pop   = (m_buf.size() != 0) && ifc.instr_ready_i;
      if (pop) begin
        pop_log.push_back(m_buf[0]);
        void'(m_buf.pop_front());
      end
      if (redir) begin
        m_stale   = grant || (m_pend && !rv) || (m_stale && !rv);
        m_pend    = 0;
        m_buf.delete();
        m_next_pc = {target[31:2], 2'b00};
      end else begin
        if (rv) begin
          if (m_pend) begin
            m_buf.push_back(m_pend_pc);
            m_pend = 0;
          end else begin
            m_stale = 0;
          end
        end
        if (grant) begin
          m_pend    = 1;
          m_pend_pc = m_next_pc;
          gnt_log.push_back(m_next_pc);
          m_next_pc = m_next_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- stimulus helpers (all start/end at posedge+1)
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect_pulse(input instr_addr_state_t s, input logic tk, input logic [31:0] t);
    ctrl_valid = 1'b1;
    st         = s;
    taken      = tk;
    target     = t;
    cycles(1);
    ctrl_valid = 1'b0;
    st         = PC4_ST;
    taken      = 1'b0;
  endtask

  // Returns at posedge+1 just after the grant edge
  task automatic wait_grant(input string name, output logic [31:0] addr);
    bit got;
    got  = 0;
    addr = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ifc.imem_req_o && ifc.imem_gnt_i) begin
        got  = 1;
        addr = ifc.imem_addr_o;
      end
    end
    chk(name, {31'b0, got}, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] log_at(input int idx);
    return (idx < pop_log.size()) ? pop_log[idx] : 32'hDEAD_DEAD;
  endfunction

  // ---------------- directed sequence
  initial begin : main
    logic [31:0] a;
    int          mc;
    bit          found;
    ifc.instr_ready_i = 1'b1;

    // Reset held for three cycles
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req",  {31'b0, ifc.imem_req_o}, 1);
    chk("boot_addr", ifc.imem_addr_o, 32'h0);
    @(posedge clk);
    #1;

    // Sequential fetch, zero-wait L1I
    pop_log.delete();
    resp_lat = 0;
    gnt_en   = 1'b1;
    cycles(8);
    gnt_en = 1'b0;
    cycles(4);
    chk("seq_pc0", log_at(0), 32'h0);
    chk("seq_pc1", log_at(1), 32'h4);
    chk("seq_pc2", log_at(2), 32'h8);

    // JAL while a slow response is in flight
    resp_lat = 2;
    gnt_en   = 1'b1;
    wait_grant("jal_grant0", a);
    pop_log.delete();
    redirect_pulse(J_ST, 1'b0, 32'h100);
    wait_grant("jal_regrant", a);
    chk("jal_addr", a, 32'h100);
    cycles(8);
    chk("jal_first_pop", log_at(0), 32'h100);

    // Branch not taken then taken
    resp_lat = 0;
    gnt_log.delete();
    redirect_pulse(B_ST, 1'b0, 32'h200);
    cycles(6);
    found = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 32'h200) found = 1;
    chk("bnt_no_jump", {31'b0, found}, 0);
    chk("bnt_progress", {31'b0, gnt_log.size() >= 2}, 1);
    redirect_pulse(B_ST, 1'b1, 32'h40);
    wait_grant("bt_grant", a);
    chk("bt_addr", a, 32'h40);

    // Backpressure: buffer fills, requests stop, then drain in order
    ifc.instr_ready_i = 1'b0;
    redirect_pulse(J_ST, 1'b0, 32'h80);
    gnt_log.delete();
    cycles(10);
    chk("bp_grants", gnt_log.size(), DEPTH);
    chk("bp_valid", {31'b0, ifc.instr_valid_o}, 1);
    chk("bp_head",  ifc.instr_pc_o, 32'h80);
    pop_log.delete();
    ifc.instr_ready_i = 1'b1;
    cycles(12);
    for (int i = 0; i < 4; i++) chk("bp_drain", log_at(i), 32'h80 + 32'(4 * i));

    // Misaligned JALR target
    mc = misalign_cnt;
    redirect_pulse(J_ST, 1'b0, 32'h103);
    wait_grant("mis_grant", a);
    chk("mis_pulses", misalign_cnt - mc, 1);
    chk("mis_addr", a, 32'h100);

    // Reset asserted while waiting on L1I
    resp_lat = 3;
    wait_grant("rst_grant", a);
    rst_n  = 1'b0;
    gnt_en = 1'b0;
    cycles(6);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_req",   {31'b0, ifc.imem_req_o}, 1);
    chk("rst2_addr",  ifc.imem_addr_o, 32'h0);
    chk("rst2_valid", {31'b0, ifc.instr_valid_o}, 0);
    @(posedge clk);
    #1;
    pop_log.delete();
    resp_lat = 0;
    gnt_en   = 1'b1;
    cycles(8);
    chk("rst2_pop0", log_at(0), 32'h0);
    chk("rst2_pop1", log_at(1), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
